debug_display_sched: RTL

//  Schedules the 8-digit HEX display between N_SRC debug requesters (CPU regs, PPU regs, mapper state, ...).

---
 rtl/debug_display_sched_if.sv | 27 ++
 rtl/debug_display_sched.sv | 136 +++++++++++++
 2 files changed

// File: rtl/debug_display_sched_if.sv
// Bundle between the debug taps / board switches and the display scheduler.
// The master side drives the requester words and board controls; the slave side returns the shown page.
interface debug_display_sched_if #(
   parameter int N_SRC = 4
) ();
   localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [N_SRC-1:0][31:0] i_src_data;
   logic [N_SRC-1:0]       i_src_valid;
   logic                   i_key_n;
   logic                   i_sw_auto;
   logic                   i_sw_freeze;
   logic [31:0]            o_word;
   logic                   o_word_vld;
   logic [PW-1:0]          o_page;
   logic                   o_frozen;

   modport master (
      output i_src_data, i_src_valid, i_key_n, i_sw_auto, i_sw_freeze,
      input  o_word, o_word_vld, o_page, o_frozen
   );

   modport slave (
      input  i_src_data, i_src_valid, i_key_n, i_sw_auto, i_sw_freeze,
      output o_word, o_word_vld, o_page, o_frozen
   );
endinterface

// File: rtl/debug_display_sched.sv
// Picks one of N_SRC debug words for the 8-digit HEX display: auto-rotate on a dwell
// timer or step with a debounced key; freeze holds the shown word.
module debug_display_sched #(
   parameter int N_SRC     = 4,
   parameter int DWELL_CYC = 50_000_000,
   parameter int DEB_CYC   = 500_000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   debug_display_sched_if.slave  bus
);
   localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int DW = $clog2(DWELL_CYC + 1);
   localparam int KW = $clog2(DEB_CYC + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHOW   = 2'd1;
   localparam logic [1:0] S_FROZEN = 2'd2;

   logic          r_key_s1, r_key_s2, r_key_db, r_press;
   logic [KW-1:0] r_deb_cnt;
   logic [1:0]    r_state;
   logic [PW-1:0] r_page;
   logic [31:0]   r_word;
   logic          r_vld, r_frozen;
   logic [DW-1:0] r_dwell;

   logic [PW-1:0] w_low_page, w_above_page, w_next_page;
   logic          w_found_above;
   logic [31:0]   w_cur_word;
   logic          w_dwell_tc, w_advance, w_any_vld;

   // Key: synchronize, then accept a new level only after DEB_CYC consecutive differing samples.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_key_s1  <= 1'b1;
         r_key_s2  <= 1'b1;
         r_key_db  <= 1'b1;
         r_deb_cnt <= '0;
         r_press   <= 1'b0;
      end else begin
         r_key_s1 <= bus.i_key_n;
         r_key_s2 <= r_key_s1;
         r_press  <= 1'b0;
         if (r_key_s2 == r_key_db) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == KW'(DEB_CYC - 1)) begin
            r_key_db  <= r_key_s2;
            r_deb_cnt <= '0;
            r_press   <= r_key_db;
         end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end
      end
   end

   // Descending scans leave the lowest valid index overall and the lowest one above r_page.
   always_comb begin
      w_low_page    = '0;
      w_above_page  = '0;
      w_found_above = 1'b0;
      for (int j = N_SRC - 1; j >= 0; j--) begin
         if (bus.i_src_valid[j]) begin
            w_low_page = PW'(j);
            if (j > int'(r_page)) begin
               w_above_page  = PW'(j);
               w_found_above = 1'b1;
            end
         end
      end
   end

   assign w_any_vld   = |bus.i_src_valid;
   assign w_next_page = w_found_above ? w_above_page : (w_any_vld ? w_low_page : r_page);
   assign w_cur_word  = bus.i_src_data[r_page];
   assign w_dwell_tc  = (r_dwell == DW'(DWELL_CYC - 1));
   assign w_advance   = !bus.i_src_valid[r_page] || r_press || (bus.i_sw_auto && w_dwell_tc);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_page   <= '0;
         r_word   <= '0;
         r_vld    <= 1'b0;
         r_frozen <= 1'b0;
         r_dwell  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_word  <= '0;
               r_vld   <= 1'b0;
               r_dwell <= '0;
               if (w_any_vld && !bus.i_sw_freeze) begin
                  r_state <= S_SHOW;
                  r_page  <= w_low_page;
                  r_word  <= bus.i_src_data[w_low_page];
                  r_vld   <= 1'b1;
               end
            end
            S_SHOW: begin
               r_word <= w_cur_word;
               if (bus.i_sw_freeze) begin
                  r_state  <= S_FROZEN;
                  r_frozen <= 1'b1;
               end else if (!w_any_vld) begin
                  r_state <= S_IDLE;
                  r_word  <= '0;
                  r_vld   <= 1'b0;
                  r_page  <= '0;
                  r_dwell <= '0;
               end else if (w_advance) begin
                  r_page  <= w_next_page;
                  r_dwell <= '0;
               end else begin
                  // Manual mode keeps the timer parked, which also clears it on a mode switch.
                  r_dwell <= bus.i_sw_auto ? r_dwell + 1'b1 : '0;
               end
            end
            S_FROZEN: begin
               if (!bus.i_sw_freeze) begin
                  r_state  <= S_SHOW;
                  r_frozen <= 1'b0;
                  r_dwell  <= '0;
                  r_word   <= w_cur_word;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_word     = r_word;
   assign bus.o_word_vld = r_vld;
   assign bus.o_page     = r_page;
   assign bus.o_frozen   = r_frozen;
endmodule
